// File: rtl/adc_spi_capture_if.sv
// ============================================================================
// Module   : adc_spi_capture_if
// Brief    : Sampler / ADC SPI / FFT-buffer signal bundle for adc_spi_capture.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface adc_spi_capture_if #(
    parameter int AW     = 4,
    parameter int DATA_W = 12
);
    logic              sample;
    logic [AW-1:0]     addr_in;
    logic              spi_sck;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              frame_done;
    logic              overrun;

    // The capture block itself.
    modport slave (
        input  sample, addr_in, spi_miso,
        output spi_sck, spi_cs_n, spi_mosi,
        output wr_en, wr_addr, wr_data, busy, frame_done, overrun
    );

    // Sampler, ADC and buffer side.
    modport master (
        output sample, addr_in, spi_miso,
        input  spi_sck, spi_cs_n, spi_mosi,
        input  wr_en, wr_addr, wr_data, busy, frame_done, overrun
    );
endinterface

`default_nettype wire

// File: rtl/adc_spi_capture.sv
// ============================================================================
// Module   : adc_spi_capture
// Brief    : Runs one SPI mode-0 ADC conversion per sample strobe and writes
//            the result to the FFT buffer at the bit-reversed sample address.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_spi_capture #(
    parameter int         N       = 16,
    parameter int         DATA_W  = 12,
    parameter int         CLK_DIV = 4,
    parameter logic [3:0] CMD     = 4'b1101
) (
    input  wire logic             clk,
    input  wire logic             rst,
    adc_spi_capture_if.slave      bus
);

    localparam int c_AW     = $clog2(N);
    localparam int c_L      = 4 + 1 + DATA_W;
    localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W  = $clog2(c_L);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(c_L - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_NULL  = c_BIT_W'(4);
    localparam logic [c_AW-1:0]    c_ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DIV_W-1:0]  r_div, w_div_nxt;
    logic [c_BIT_W-1:0]  r_bit, w_bit_nxt;
    logic                r_high, w_high_nxt;
    logic [c_AW-1:0]     r_addr;
    logic [DATA_W-2:0]   r_shift;
    logic [c_AW-1:0]     r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_overrun;
    logic                w_div_last;
    logic                w_load;
    logic                w_shift_in;
    logic                w_capture;
    logic                w_mosi;
    logic [c_AW-1:0]     w_addr_rev;

    assign w_div_last = (r_div == c_DIV_LAST);

    for (genvar i = 0; i < c_AW; i++) begin : g_rev
        assign w_addr_rev[i] = r_addr[c_AW-1-i];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_high_nxt  = r_high;
        w_load      = 1'b0;
        w_shift_in  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.sample) begin
                    w_state_nxt = S_SETUP;
                    w_div_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_div_last) begin
                    w_state_nxt = S_SHIFT;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_high_nxt  = 1'b0;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            S_SHIFT: begin
                if (!w_div_last) begin
                    w_div_nxt = r_div + 1'b1;
                end else if (!r_high) begin
                    w_div_nxt  = '0;
                    w_high_nxt = 1'b1;
                end else begin
                    // End of a high half: MISO is sampled here, null bit dropped.
                    w_div_nxt  = '0;
                    w_high_nxt = 1'b0;
                    w_shift_in = (r_bit > c_BIT_NULL);
                    if (r_bit == c_BIT_LAST) begin
                        w_state_nxt = S_WRITE;
                        w_capture   = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_state_nxt = S_HOLD;
                w_div_nxt   = '0;
            end
            S_HOLD: begin
                if (w_div_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_high  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_high  <= w_high_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_shift   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_addr  <= bus.addr_in;
                r_shift <= '0;
            end else if (w_shift_in) begin
                r_shift <= {r_shift[DATA_W-3:0], bus.spi_miso};
            end
            // The final data bit goes straight into the output register.
            if (w_capture) begin
                r_wr_data <= {r_shift, bus.spi_miso};
                r_wr_addr <= w_addr_rev;
            end
            if (bus.sample && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (w_load && (bus.addr_in == '0)) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_mosi = 1'b0;
        if (r_state == S_SETUP) begin
            w_mosi = CMD[3];
        end else if ((r_state == S_SHIFT) && (r_bit < c_BIT_NULL)) begin
            w_mosi = CMD[~r_bit[1:0]];
        end
    end

    assign bus.spi_sck    = (r_state == S_SHIFT) && r_high;
    assign bus.spi_cs_n   = !((r_state == S_SETUP) || (r_state == S_SHIFT));
    assign bus.spi_mosi   = w_mosi;
    assign bus.wr_en      = (r_state == S_WRITE);
    assign bus.frame_done = (r_state == S_WRITE) && (r_addr == c_ADDR_LAST);
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_capture.sv
// ============================================================================
// Module   : tb_adc_spi_capture
// Brief    : Directed self-checking bench for adc_spi_capture with an ADC model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adc_spi_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_spi_capture_if #(.AW(4), .DATA_W(12)) bus  ();
    adc_spi_capture_if #(.AW(4), .DATA_W(12)) bus1 ();

    adc_spi_capture #(.N(16), .DATA_W(12), .CLK_DIV(4), .CMD(4'b1101)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    adc_spi_capture #(.N(16), .DATA_W(12), .CLK_DIV(1), .CMD(4'b1101)) u_dut_div1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: bit period b carries 0 for b<=4, then data MSB first.
    logic [11:0] adc_val = 12'h000;
    int          rise_total = 0;
    int          rise_base  = 0;
    logic [16:0] mosi_cap   = '0;

    function automatic logic adc_bit(input logic [11:0] v, input int b);
        if (b >= 5 && b <= 16) return v[16-b];
        return 1'b0;
    endfunction

    assign bus.spi_miso  = adc_bit(adc_val, rise_total - rise_base - (bus.spi_sck ? 1 : 0));
    assign bus1.spi_miso = 1'b1;

    always @(negedge bus.spi_cs_n) rise_base <= rise_total;
    always @(posedge bus.spi_sck) begin
        if ((rise_total - rise_base) >= 0 && (rise_total - rise_base) < 17)
            mosi_cap[rise_total - rise_base] <= bus.spi_mosi;
        rise_total <= rise_total + 1;
    end

    // Event monitor, sampled on the falling clock edge.
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0, prev_cs1 = 1'b1;
    int cs_fall_cyc = 0, first_rise_cyc = -1, busy_fall_cyc = 0;
    int wr_cnt = 0, fd_cnt = 0, fd_bad = 0, last_wr_cyc = 0;
    logic [3:0]  last_wr_addr = '0;
    logic [11:0] last_wr_data = '0;
    logic        last_fd = 1'b0;
    int cs1_fall_cyc = 0, wr1_cyc = 0, wr1_cnt = 0;
    logic [3:0]  wr1_addr = '0;
    logic [11:0] wr1_data = '0;

    always @(negedge clk) begin
        if (!bus.spi_cs_n && prev_cs) begin
            cs_fall_cyc    <= cyc;
            first_rise_cyc <= -1;
        end else if (bus.spi_sck && !prev_sck && first_rise_cyc < 0) begin
            first_rise_cyc <= cyc;
        end
        if (!bus.busy && prev_busy) busy_fall_cyc <= cyc;
        if (bus.wr_en) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_cyc  <= cyc;
            last_wr_addr <= bus.wr_addr;
            last_wr_data <= bus.wr_data;
            last_fd      <= bus.frame_done;
            if (bus.frame_done) fd_cnt <= fd_cnt + 1;
        end
        if (bus.frame_done && !bus.wr_en) fd_bad <= fd_bad + 1;
        prev_cs   <= bus.spi_cs_n;
        prev_sck  <= bus.spi_sck;
        prev_busy <= bus.busy;
        if (!bus1.spi_cs_n && prev_cs1) cs1_fall_cyc <= cyc;
        if (bus1.wr_en) begin
            wr1_cnt  <= wr1_cnt + 1;
            wr1_cyc  <= cyc;
            wr1_addr <= bus1.wr_addr;
            wr1_data <= bus1.wr_data;
        end
        prev_cs1 <= bus1.spi_cs_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_sample(input logic [3:0] a);
        @(posedge clk);
        #1 bus.sample = 1'b1;
        bus.addr_in = a;
        @(posedge clk);
        #1 bus.sample = 1'b0;
    endtask

    function automatic logic [31:0] ctl_vec();
        return 32'({bus.spi_sck, bus.spi_cs_n, bus.spi_mosi, bus.wr_en,
                    bus.busy, bus.frame_done, bus.overrun});
    endfunction

    logic [3:0] rev_tab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                 4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
    int base, fd_base, c0;

    initial begin
        bus.sample   = 1'b0;
        bus.addr_in  = '0;
        bus1.sample  = 1'b0;
        bus1.addr_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl",   ctl_vec(), 32'h20);
        chk("reset_waddr", 32'(bus.wr_addr), 32'h0);
        chk("reset_wdata", 32'(bus.wr_data), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single conversion, address 3 -> 12.
        adc_val = 12'hA5C;
        base = wr_cnt;
        do_sample(4'd3);
        repeat (150) @(posedge clk);
        #1;
        chk("single_wrcnt",   32'(wr_cnt - base), 32'd1);
        chk("single_latency", 32'(last_wr_cyc - cs_fall_cyc), 32'd140);
        chk("single_sck1",    32'(first_rise_cyc - cs_fall_cyc), 32'd8);
        chk("single_rises",   32'(rise_total - rise_base), 32'd17);
        chk("single_mosi",    32'(mosi_cap), 32'h0000B);
        chk("single_data",    32'(last_wr_data), 32'hA5C);
        chk("single_addr",    32'(last_wr_addr), 32'd12);
        chk("single_fd",      32'(last_fd), 32'd0);
        chk("single_busy",    32'(busy_fall_cyc - last_wr_cyc), 32'd5);

        // Full frame at bit-reversed addresses.
        fd_base = fd_cnt;
        for (int i = 0; i < 16; i++) begin
            adc_val = 12'(100 + i);
            base = wr_cnt;
            do_sample(4'(i));
            repeat (150) @(posedge clk);
            #1;
            chk("frame_wrcnt", 32'(wr_cnt - base), 32'd1);
            chk("frame_addr",  32'(last_wr_addr), 32'(rev_tab[i]));
            chk("frame_data",  32'(last_wr_data), 32'(100 + i));
            chk("frame_fd",    32'(last_fd), (i == 15) ? 32'd1 : 32'd0);
        end
        chk("frame_fdcnt",   32'(fd_cnt - fd_base), 32'd1);
        chk("frame_fdbad",   32'(fd_bad), 32'd0);
        chk("frame_overrun", 32'(bus.overrun), 32'd0);

        // Overrun: second sample dropped, first write intact.
        adc_val = 12'h3C7;
        base = wr_cnt;
        do_sample(4'd5);
        repeat (48) @(posedge clk);
        do_sample(4'd9);
        chk("ovr_set",   32'(bus.overrun), 32'd1);
        chk("ovr_busy",  32'(bus.busy), 32'd1);
        repeat (300) @(posedge clk);
        #1;
        chk("ovr_wrcnt", 32'(wr_cnt - base), 32'd1);
        chk("ovr_data",  32'(last_wr_data), 32'h3C7);
        chk("ovr_addr",  32'(last_wr_addr), 32'd10);
        chk("ovr_sticky", 32'(bus.overrun), 32'd1);
        adc_val = 12'h0F0;
        do_sample(4'd0);
        chk("ovr_clear", 32'(bus.overrun), 32'd0);
        repeat (150) @(posedge clk);
        #1;
        chk("ovr_next_data", 32'(last_wr_data), 32'h0F0);

        // Back-to-back: second sample in the first idle cycle.
        adc_val = 12'h123;
        base = wr_cnt;
        do_sample(4'd1);
        repeat (145) @(posedge clk);
        c0 = cs_fall_cyc;
        adc_val = 12'h456;
        #1 bus.sample = 1'b1;
        bus.addr_in = 4'd2;
        @(posedge clk);
        #1 bus.sample = 1'b0;
        chk("b2b_busy",    32'(bus.busy), 32'd1);
        chk("b2b_overrun", 32'(bus.overrun), 32'd0);
        repeat (150) @(posedge clk);
        #1;
        chk("b2b_wrcnt",   32'(wr_cnt - base), 32'd2);
        chk("b2b_latency", 32'(last_wr_cyc - c0), 32'd286);
        chk("b2b_data",    32'(last_wr_data), 32'h456);
        chk("b2b_addr",    32'(last_wr_addr), 32'd4);

        // Asynchronous reset in the middle of SHIFT.
        adc_val = 12'h777;
        base = wr_cnt;
        do_sample(4'd4);
        repeat (60) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_ctl",   ctl_vec(), 32'h20);
        chk("rst_waddr", 32'(bus.wr_addr), 32'h0);
        chk("rst_wdata", 32'(bus.wr_data), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        chk("rst_nowr", 32'(wr_cnt - base), 32'd0);
        adc_val = 12'h5A3;
        do_sample(4'd7);
        repeat (150) @(posedge clk);
        #1;
        chk("rst_next_wrcnt", 32'(wr_cnt - base), 32'd1);
        chk("rst_next_data",  32'(last_wr_data), 32'h5A3);
        chk("rst_next_addr",  32'(last_wr_addr), 32'd14);
        chk("rst_next_lat",   32'(last_wr_cyc - cs_fall_cyc), 32'd140);

        // CLK_DIV=1 instance, MISO tied high.
        @(posedge clk);
        #1 bus1.sample = 1'b1;
        bus1.addr_in = 4'd2;
        @(posedge clk);
        #1 bus1.sample = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("div1_wrcnt",   32'(wr1_cnt), 32'd1);
        chk("div1_data",    32'(wr1_data), 32'hFFF);
        chk("div1_addr",    32'(wr1_addr), 32'd4);
        chk("div1_latency", 32'(wr1_cyc - cs1_fall_cyc), 32'd35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
